ps2_keyboard_rx: RTL

PS/2 keyboard receiver that produces the `curPressed` scancode consumed by the game engine's player-movement and match-reset logic. It samples the keyboard's open-collector clock/data lines in the 50 MHz `clk` domain, deglitches them, and deframes 11-bit PS/2 frames. It then tracks make/break sequences, so `curPressed` holds the make code of the currently held key and returns to 0x00 when that key is released.

---
 rtl/ps2_pkg.sv | 30 +++
 rtl/ps2_frame_rx.sv | 165 ++++++++++++++++
 rtl/ps2_keyboard_rx.sv | 63 ++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: frame-state encoding, protocol prefix bytes and
// the game scancodes also referenced by the game engine.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } frame_state_t;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    localparam logic [7:0] SC_W = 8'h1D;
    localparam logic [7:0] SC_D = 8'h23;
    localparam logic [7:0] SC_S = 8'h1B;
    localparam logic [7:0] SC_A = 8'h1C;
    localparam logic [7:0] SC_I = 8'h43;
    localparam logic [7:0] SC_L = 8'h4B;
    localparam logic [7:0] SC_K = 8'h42;
    localparam logic [7:0] SC_J = 8'h3B;
    localparam logic [7:0] SC_R = 8'h2D;

    // PS/2 uses odd parity over the eight data bits plus the parity bit
    function automatic logic parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronizes and deglitches the keyboard lines and
// deframes 11-bit frames into rxByte/rxValid/frameErr.
// Optional build macro: PS2_TIMEOUT_EN (aborts a stalled partial frame).
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2Clk,
    input  logic       ps2Data,
    output logic [7:0] rxByte,
    output logic       rxValid,
    output logic       frameErr
);

    logic                  clk_s1, clk_s2, dat_s1, dat_s2;
    logic [FILTER_LEN-1:0] filt_sr;
    logic                  filt_clk;
    logic                  fall;
    logic                  filt_edge;

    frame_state_t state, state_n;
    logic [2:0]   bitcnt;
    logic [7:0]   shreg;
    logic         par_bit;
    logic         ok_n, err_n;
    logic         timeout;

    // Two-flop synchronizers; reset to the idle-high bus level
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2Clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2Data;
            dat_s2 <= dat_s1;
        end
    end

    // Glitch filter: level changes only when the whole window agrees
    always_ff @(posedge clk) begin
        if (rst) begin
            filt_sr   <= '1;
            filt_clk  <= 1'b1;
            fall      <= 1'b0;
            filt_edge <= 1'b0;
        end else begin
            filt_sr   <= {filt_sr[FILTER_LEN-2:0], clk_s2};
            fall      <= 1'b0;
            filt_edge <= 1'b0;
            if (filt_sr == '0 && filt_clk) begin
                filt_clk  <= 1'b0;
                fall      <= 1'b1;
                filt_edge <= 1'b1;
            end else if (filt_sr == '1 && !filt_clk) begin
                filt_clk  <= 1'b1;
                filt_edge <= 1'b1;
            end
        end
    end

`ifdef PS2_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TO_W-1:0] to_cnt;

    // Inactivity counter, held clear while idle or on any filtered edge
    always_ff @(posedge clk) begin
        if (rst || filt_edge || state == IDLE) begin
            to_cnt <= '0;
        end else if (!timeout) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // Timeout never coincides with fall, since fall implies filt_edge
    always_comb begin
        timeout = (state != IDLE) && !filt_edge && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    end
`else
    // Timeout logic not built; parameter kept for interface compatibility
    always_comb begin
        timeout = 1'b0 & (TIMEOUT_CYCLES == 0);
    end
`endif

    // Frame state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic, stepped by filtered falling edges
    always_comb begin
        state_n = state;
        if (timeout) begin
            state_n = IDLE;
        end else if (fall) begin
            case (state)
                IDLE:    if (!dat_s2) state_n = DATA;
                DATA:    if (bitcnt == 3'd7) state_n = PARITY;
                PARITY:  state_n = STOP;
                STOP:    state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    // Frame outcome strobes, valid during the stop-bit fall
    always_comb begin
        ok_n  = 1'b0;
        err_n = timeout;
        if (fall && state == STOP) begin
            if (dat_s2 && parity_ok(shreg, par_bit)) begin
                ok_n = 1'b1;
            end else begin
                err_n = 1'b1;
            end
        end
    end

    // Shift register, bit counter and parity capture
    always_ff @(posedge clk) begin
        if (rst) begin
            bitcnt  <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
        end else if (fall) begin
            case (state)
                IDLE:   bitcnt <= '0;
                DATA: begin
                    shreg  <= {dat_s2, shreg[7:1]};
                    bitcnt <= bitcnt + 3'd1;
                end
                PARITY: par_bit <= dat_s2;
                default: ;
            endcase
        end
    end

    // Registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            rxByte   <= '0;
            rxValid  <= 1'b0;
            frameErr <= 1'b0;
        end else begin
            rxValid  <= ok_n;
            frameErr <= err_n;
            if (ok_n) begin
                rxByte <= shreg;
            end
        end
    end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver top: frame receiver plus make/break decoder that
// keeps curPressed at the make code of the held key (0x00 when released).
// Optional build macro: PS2_TIMEOUT_EN (passed through to ps2_frame_rx).
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2Clk,
    input  logic       ps2Data,
    output logic [7:0] curPressed,
    output logic [7:0] rxByte,
    output logic       rxValid,
    output logic       frameErr
);

    logic breakPending;
    logic extPending;

    ps2_frame_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_frame (
        .clk      (clk),
        .rst      (rst),
        .ps2Clk   (ps2Clk),
        .ps2Data  (ps2Data),
        .rxByte   (rxByte),
        .rxValid  (rxValid),
        .frameErr (frameErr)
    );

    // Make/break decoder; the E0 prefix is tracked but otherwise ignored
    always_ff @(posedge clk) begin
        if (rst) begin
            curPressed   <= '0;
            breakPending <= 1'b0;
            extPending   <= 1'b0;
        end else if (rxValid) begin
            if (rxByte == SC_BREAK) begin
                breakPending <= 1'b1;
            end else if (rxByte == SC_EXT) begin
                extPending <= 1'b1;
            end else begin
                if (breakPending) begin
                    if (rxByte == curPressed) begin
                        curPressed <= '0;
                    end
                    breakPending <= 1'b0;
                end else begin
                    curPressed <= rxByte;
                end
                if (extPending) begin
                    extPending <= 1'b0;
                end
            end
        end
    end

endmodule
